pcie_us_axis_rc_tag_demux: RTL and testbench
============================================

PCIE_US_AXIS_RC_TAG_DEMUX -- requirements
Module: pcie_us_axis_rc_tag_demux

Interface
REQ-001 SHALL have parameter M_COUNT, default 4, number of outputs, legal 1..16.
REQ-002 SHALL have parameter AXIS_PCIE_DATA_WIDTH, default 256, legal 128/256/512; any other value is an elaboration error.
REQ-003 SHALL have parameter AXIS_PCIE_KEEP_WIDTH, default AXIS_PCIE_DATA_WIDTH/32; KEEP_WIDTH*32 != DATA_WIDTH is an elaboration error.
REQ-004 SHALL have parameter AXIS_PCIE_RC_USER_WIDTH, default 75 if DATA_WIDTH<512 else 161.
REQ-005 SHALL have parameter TAG_LSB, default 64, bit position of the completion tag in first-beat tdata.
REQ-006 SHALL have parameter TAG_WIDTH, default 8, legal 1..10.
REQ-007 SHALL have parameter SEL_SHIFT, default 5, tag right-shift giving the output index.
REQ-008 clk  input  1  rising-edge clock for all state.
REQ-009 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-010 s_axis_rc_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA/KEEP/1/1/1/USER  RC completion input stream.
REQ-011 m_axis_rc_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  M_COUNT x (DATA/KEEP/1/1/1/USER)  per-output RC streams.
REQ-012 enable  input  1  gates s_axis_rc_tready.
REQ-013 out_enable  input  M_COUNT  per-output enable; a frame routed to a disabled output is dropped.
REQ-014 drop_count  output  32  saturating count of dropped frames.
REQ-015 cur_tag  output  TAG_WIDTH  combinational tdata[TAG_LSB +: TAG_WIDTH] of the current input beat.

Function
REQ-016 At first beat of a frame (no frame in progress, tvalid&&tready), sel = tag >> SEL_SHIFT SHALL be latched for the whole frame.
REQ-017 Frame SHALL be dropped if sel >= M_COUNT or out_enable[sel]==0, evaluated at first beat only; later changes ignored until tlast.
REQ-018 Dropped beats SHALL be accepted (tready asserted, given enable) and never appear on any output.
REQ-019 drop_count SHALL increment by 1 per dropped frame at its first beat, saturating at 0xFFFFFFFF.
REQ-020 Single-beat frame (tlast on first beat) SHALL route/drop on that beat and leave the frame state idle.
REQ-021 s_axis_rc_tready SHALL equal registered ready AND enable; registered ready = output-early-ready OR current drop decision.
REQ-022 Output stage SHALL be a 2-entry skid (output reg + temp reg) shared by all outputs, with per-output one-hot tvalid; tdata/tkeep/tlast/tuser replicated to all outputs.
REQ-023 Latency input-accept to output-valid SHALL be 1 cycle; full throughput (1 beat/cycle) when destination tready stays high.
REQ-024 Early-ready SHALL be (|(m_tready & m_tvalid)) OR (temp empty AND (output empty OR no incoming valid)); no beat SHALL ever be lost or duplicated.
REQ-025 A stalled selected output SHALL backpressure the input (head-of-line blocking accepted); other outputs' tvalid SHALL stay 0.
REQ-026 Beats SHALL leave in acceptance order; tdata/tkeep/tlast/tuser unmodified.
REQ-027 At most one bit of m_axis_rc_tvalid SHALL be set in any cycle.

Reset
REQ-028 While rst_n=0: all m_axis_rc_tvalid=0, s_axis_rc_tready=0, temp valid=0, frame/drop state idle, select=0, drop_count=0.
REQ-029 Reset mid-frame SHALL discard the in-flight frame; first beat after reset release SHALL be treated as start of frame.
REQ-030 s_axis_rc_tready SHALL assert no earlier than the second rising edge after rst_n deassertion.

Verification
REQ-031 3-beat frame tag=0x45, SEL_SHIFT=5, all outputs ready/enabled -> 3 beats on output 2 only, one cycle after each acceptance, tlast on beat 3.
REQ-032 Tag=0x9F (sel=4, M_COUNT=4) single-beat frame -> no output valid, tready stays 1, drop_count 0->1.
REQ-033 Output 1 frame, m_axis_rc_tready[1]=0 for 5 cycles mid-frame -> input tready deasserts within 2 cycles, all beats delivered in order after release, none lost.
REQ-034 out_enable[0] toggled 1->0 after first beat of a tag=0x03 frame -> whole frame still delivered to output 0; next tag=0x03 frame dropped.
REQ-035 Back-to-back single-beat frames tags 0x00,0x20,0x40,0x60 every cycle -> outputs 0,1,2,3 each valid in consecutive cycles, zero bubbles.
REQ-036 rst_n pulsed low during beat 2 of a 4-beat frame -> all outputs valid 0 immediately, drop_count 0, next frame routed by its own first-beat tag.

Source files
------------

// File: rtl/pcie_us_axis_rc_tag_demux_if.sv
// Stream bundle for the RC tag demux. N lanes pack each field into one
// vector, so the same type carries the single input and all outputs.
interface pcie_us_axis_rc_tag_demux_if #(
    parameter int N      = 1,
    parameter int DATA_W = 256,
    parameter int KEEP_W = 8,
    parameter int USER_W = 75
);
    logic [N*DATA_W-1:0] tdata;
    logic [N*KEEP_W-1:0] tkeep;
    logic [N-1:0]        tvalid;
    logic [N-1:0]        tready;
    logic [N-1:0]        tlast;
    logic [N*USER_W-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/pcie_us_axis_rc_tag_demux.sv
// PCIe UltraScale RC completion demux: each frame goes to the output picked
// by its tag; frames for missing or disabled outputs are dropped and counted.
module pcie_us_axis_rc_tag_demux #(
    parameter int M_COUNT                 = 4,
    parameter int AXIS_PCIE_DATA_WIDTH    = 256,
    parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
    parameter int AXIS_PCIE_RC_USER_WIDTH =
        AXIS_PCIE_DATA_WIDTH < 512 ? 75 : 161,
    parameter int TAG_LSB                 = 64,
    parameter int TAG_WIDTH               = 8,
    parameter int SEL_SHIFT               = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pcie_us_axis_rc_tag_demux_if.slave  s_axis_rc,
    pcie_us_axis_rc_tag_demux_if.master m_axis_rc,
    input  logic                        enable,
    input  logic [M_COUNT-1:0]          out_enable,
    output logic [31:0]                 drop_count,
    output logic [TAG_WIDTH-1:0]        cur_tag
);
    localparam int DW   = AXIS_PCIE_DATA_WIDTH;
    localparam int KW   = AXIS_PCIE_KEEP_WIDTH;
    localparam int UW   = AXIS_PCIE_RC_USER_WIDTH;
    localparam int SELW = M_COUNT > 1 ? $clog2(M_COUNT) : 1;

    generate
        if (!(DW == 128 || DW == 256 || DW == 512)) begin : g_bad_dw
            $error("AXIS_PCIE_DATA_WIDTH must be 128, 256 or 512");
        end
        if (KW * 32 != DW) begin : g_bad_kw
            $error("AXIS_PCIE_KEEP_WIDTH * 32 must equal data width");
        end
        if (M_COUNT < 1 || M_COUNT > 16) begin : g_bad_m
            $error("M_COUNT must be in 1..16");
        end
        if (TAG_WIDTH < 1 || TAG_WIDTH > 10) begin : g_bad_tw
            $error("TAG_WIDTH must be in 1..10");
        end
        if (TAG_LSB < 0 || TAG_LSB + TAG_WIDTH > DW) begin : g_bad_lsb
            $error("tag field must lie inside tdata");
        end
    endgenerate

    logic                 rst_done_q;
    logic                 ready_q, ready_d;
    logic                 frame_q, frame_d;
    logic                 drop_q, drop_d;
    logic [SELW-1:0]      select_q, select_d;
    logic [31:0]          drop_cnt_q, drop_cnt_d;

    logic [M_COUNT-1:0]   out_valid_q, out_valid_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic [KW-1:0]        out_keep_q, out_keep_d;
    logic [UW-1:0]        out_user_q, out_user_d;
    logic                 out_last_q, out_last_d;

    logic [M_COUNT-1:0]   tmp_valid_q, tmp_valid_d;
    logic [DW-1:0]        tmp_data_q, tmp_data_d;
    logic [KW-1:0]        tmp_keep_q, tmp_keep_d;
    logic [UW-1:0]        tmp_user_q, tmp_user_d;
    logic                 tmp_last_q, tmp_last_d;

    logic [TAG_WIDTH-1:0] sel_full;
    logic                 sel_hit;
    logic [SELW-1:0]      sel_now;
    logic                 drop_now;
    logic                 accept;
    logic [M_COUNT-1:0]   in_valid;
    logic                 out_drain;
    logic                 early_ready;
    logic                 to_out, to_tmp, tmp_to_out;

    assign cur_tag            = s_axis_rc.tdata[TAG_LSB +: TAG_WIDTH];
    assign sel_full           = cur_tag >> SEL_SHIFT;
    assign s_axis_rc.tready   = ready_q & enable;
    assign accept             = s_axis_rc.tvalid[0] & ready_q & enable;

    assign m_axis_rc.tvalid   = out_valid_q;
    assign m_axis_rc.tdata    = {M_COUNT{out_data_q}};
    assign m_axis_rc.tkeep    = {M_COUNT{out_keep_q}};
    assign m_axis_rc.tuser    = {M_COUNT{out_user_q}};
    assign m_axis_rc.tlast    = {M_COUNT{out_last_q}};
    assign drop_count         = drop_cnt_q;

    // Routing decision: live from the tag on a first beat, latched otherwise.
    always_comb begin
        sel_hit = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (32'(sel_full) == 32'(i)) begin
                sel_hit = out_enable[i];
            end
        end
        sel_now  = frame_q ? select_q : SELW'(sel_full);
        drop_now = frame_q ? drop_q : !sel_hit;
        in_valid = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            in_valid[i] = accept && !drop_now && (sel_now == SELW'(i));
        end
    end

    always_comb begin
        frame_d    = frame_q;
        drop_d     = drop_q;
        select_d   = select_q;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            if (!frame_q) begin
                select_d = sel_now;
                drop_d   = drop_now;
                if (drop_now && drop_cnt_q != 32'hFFFF_FFFF) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                end
            end
            frame_d = !s_axis_rc.tlast[0];
            if (s_axis_rc.tlast[0]) begin
                drop_d = 1'b0;
            end
        end
    end

    // Shared two-entry skid; ready is registered so the temp entry absorbs
    // the beat that arrives in the cycle the selected output stalls.
    always_comb begin
        out_drain   = |(m_axis_rc.tready & out_valid_q);
        early_ready = out_drain ||
                      (!(|tmp_valid_q) && (!(|out_valid_q) || !(|in_valid)));
        ready_d     = rst_done_q && (early_ready || drop_d);

        out_valid_d = out_valid_q;
        tmp_valid_d = tmp_valid_q;
        to_out      = 1'b0;
        to_tmp      = 1'b0;
        tmp_to_out  = 1'b0;
        if (ready_q) begin
            if (out_drain || !(|out_valid_q)) begin
                out_valid_d = in_valid;
                to_out      = 1'b1;
            end else begin
                tmp_valid_d = in_valid;
                to_tmp      = 1'b1;
            end
        end else if (out_drain) begin
            out_valid_d = tmp_valid_q;
            tmp_valid_d = '0;
            tmp_to_out  = 1'b1;
        end

        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_user_d = out_user_q;
        out_last_d = out_last_q;
        tmp_data_d = tmp_data_q;
        tmp_keep_d = tmp_keep_q;
        tmp_user_d = tmp_user_q;
        tmp_last_d = tmp_last_q;
        if (to_out) begin
            out_data_d = s_axis_rc.tdata;
            out_keep_d = s_axis_rc.tkeep;
            out_user_d = s_axis_rc.tuser;
            out_last_d = s_axis_rc.tlast[0];
        end else if (tmp_to_out) begin
            out_data_d = tmp_data_q;
            out_keep_d = tmp_keep_q;
            out_user_d = tmp_user_q;
            out_last_d = tmp_last_q;
        end
        if (to_tmp) begin
            tmp_data_d = s_axis_rc.tdata;
            tmp_keep_d = s_axis_rc.tkeep;
            tmp_user_d = s_axis_rc.tuser;
            tmp_last_d = s_axis_rc.tlast[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q  <= 1'b0;
            ready_q     <= 1'b0;
            frame_q     <= 1'b0;
            drop_q      <= 1'b0;
            select_q    <= '0;
            drop_cnt_q  <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
            tmp_valid_q <= '0;
            tmp_data_q  <= '0;
            tmp_keep_q  <= '0;
            tmp_user_q  <= '0;
            tmp_last_q  <= 1'b0;
        end else begin
            rst_done_q  <= 1'b1;
            ready_q     <= ready_d;
            frame_q     <= frame_d;
            drop_q      <= drop_d;
            select_q    <= select_d;
            drop_cnt_q  <= drop_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
            tmp_valid_q <= tmp_valid_d;
            tmp_data_q  <= tmp_data_d;
            tmp_keep_q  <= tmp_keep_d;
            tmp_user_q  <= tmp_user_d;
            tmp_last_q  <= tmp_last_d;
        end
    end
endmodule

// File: tb/tb_pcie_us_axis_rc_tag_demux.sv
// Bench for pcie_us_axis_rc_tag_demux: directed vectors, corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_pcie_us_axis_rc_tag_demux;
    localparam int M  = 4;
    localparam int DW = 256;
    localparam int KW = 8;
    localparam int UW = 75;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    typedef struct {
        logic [7:0] tag;
        logic [3:0] en;
        logic [3:0] exp_v;
        bit         exp_drop;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [M-1:0] out_enable = '1;
    logic [31:0]  drop_count;
    logic [7:0]   cur_tag;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t       expq [M][$];
    bit          mdl_frame = 1'b0;
    int          mdl_dest = -1;
    int unsigned mdl_drops = 0;

    always #5 clk = ~clk;

    pcie_us_axis_rc_tag_demux_if #(
        .N(1), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW)
    ) s_if ();
    pcie_us_axis_rc_tag_demux_if #(
        .N(M), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW)
    ) m_if ();

    pcie_us_axis_rc_tag_demux #(
        .M_COUNT(M),
        .AXIS_PCIE_DATA_WIDTH(DW),
        .AXIS_PCIE_KEEP_WIDTH(KW),
        .AXIS_PCIE_RC_USER_WIDTH(UW),
        .TAG_LSB(64),
        .TAG_WIDTH(8),
        .SEL_SHIFT(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_rc(s_if),
        .m_axis_rc(m_if),
        .enable(enable),
        .out_enable(out_enable),
        .drop_count(drop_count),
        .cur_tag(cur_tag)
    );

    task automatic check(input string name, input logic [511:0] act,
                         input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: output index is tag/32, frame routed by its first beat only.
    task automatic monitor();
        beat_t got;
        beat_t e;
        int    sel;
        if (|m_if.tvalid)
            check("tvalid_onehot", 512'($countones(m_if.tvalid)), 512'(1));
        for (int i = 0; i < M; i++) begin
            if (m_if.tvalid[i] && m_if.tready[i]) begin
                got = {m_if.tdata[i*DW +: DW], m_if.tkeep[i*KW +: KW],
                       m_if.tuser[i*UW +: UW], m_if.tlast[i]};
                if (expq[i].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out%0d_unexpected: got beat %h, required none",
                             i, got.d);
                end else begin
                    e = expq[i].pop_front();
                    check($sformatf("out%0d_beat", i), 512'(got), 512'(e));
                end
            end
        end
        if (s_if.tvalid[0] && s_if.tready[0]) begin
            if (!mdl_frame) begin
                sel = int'(s_if.tdata[71:64]) / 32;
                mdl_dest = -1;
                if (sel < M) begin
                    if (out_enable[sel]) mdl_dest = sel;
                end
                if (mdl_dest < 0 && mdl_drops != 32'hFFFF_FFFF) mdl_drops++;
            end
            if (mdl_dest >= 0)
                expq[mdl_dest].push_back({s_if.tdata, s_if.tkeep,
                                          s_if.tuser, s_if.tlast[0]});
            mdl_frame = !s_if.tlast[0];
        end
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = s_if.tvalid[0] && s_if.tready[0];
        if (rst_n) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] tag, input bit first, input bit last);
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        if (first) d[71:64] = tag;
        s_if.tdata  = d;
        s_if.tkeep  = KW'($urandom);
        s_if.tuser  = UW'({$urandom, $urandom, $urandom});
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
    endtask

    task automatic wait_acc(output int cycles);
        bit acc = 1'b0;
        cycles = 0;
        while (!acc && cycles < 100) begin
            tick(acc);
            cycles++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: beat not accepted, required within 100 cycles");
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic send(input logic [7:0] tag, input bit first, input bit last);
        int cyc;
        drive(tag, first, last);
        wait_acc(cyc);
    endtask

    vec_t        vecs [12];
    bit          acc;
    int          cyc;
    int          nb;
    logic [31:0] d0;
    logic [7:0]  rtag;
    int          len;

    initial begin
        vecs[0]  = '{8'h00, 4'b1111, 4'b0001, 1'b0};
        vecs[1]  = '{8'h3F, 4'b1111, 4'b0010, 1'b0};
        vecs[2]  = '{8'h20, 4'b1111, 4'b0010, 1'b0};
        vecs[3]  = '{8'h45, 4'b1111, 4'b0100, 1'b0};
        vecs[4]  = '{8'h7F, 4'b1111, 4'b1000, 1'b0};
        vecs[5]  = '{8'h80, 4'b1111, 4'b0000, 1'b1};
        vecs[6]  = '{8'h9F, 4'b1111, 4'b0000, 1'b1};
        vecs[7]  = '{8'hFF, 4'b1111, 4'b0000, 1'b1};
        vecs[8]  = '{8'h03, 4'b1110, 4'b0000, 1'b1};
        vecs[9]  = '{8'h25, 4'b1101, 4'b0000, 1'b1};
        vecs[10] = '{8'h61, 4'b1000, 4'b1000, 1'b0};
        vecs[11] = '{8'h41, 4'b1011, 4'b0000, 1'b1};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = '1;
        enable      = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 512'(m_if.tvalid), 512'(0));
        check("rst_tready", 512'(s_if.tready), 512'(0));
        check("rst_drop_count", 512'(drop_count), 512'(0));
        #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("tready_after_edge1", 512'(s_if.tready), 512'(0));
        @(posedge clk);
        @(negedge clk);
        check("tready_after_edge2", 512'(s_if.tready), 512'(1));
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            out_enable = vecs[i].en;
            d0 = drop_count;
            drive(vecs[i].tag, 1'b1, 1'b1);
            check($sformatf("vec%0d_cur_tag", i), 512'(cur_tag), 512'(vecs[i].tag));
            wait_acc(cyc);
            check($sformatf("vec%0d_tvalid", i), 512'(m_if.tvalid), 512'(vecs[i].exp_v));
            check($sformatf("vec%0d_drops", i), 512'(drop_count),
                  512'(d0 + 32'(vecs[i].exp_drop)));
        end
        out_enable = '1;
        tick(acc);

        for (int b = 0; b < 3; b++) begin
            send(8'h45, b == 0, b == 2);
            check($sformatf("tag45_b%0d_tvalid", b), 512'(m_if.tvalid), 512'(4'b0100));
            check($sformatf("tag45_b%0d_tlast", b), 512'(m_if.tlast[2]), 512'(b == 2));
        end
        tick(acc);

        d0 = drop_count;
        send(8'h9F, 1'b1, 1'b1);
        check("tag9f_tvalid", 512'(m_if.tvalid), 512'(0));
        check("tag9f_tready", 512'(s_if.tready), 512'(1));
        check("tag9f_drops", 512'(drop_count), 512'(d0 + 32'd1));

        nb = 0;
        drive(8'h20, 1'b1, 1'b0);
        for (int c = 0; c < 60 && nb < 8; c++) begin
            m_if.tready[1] = !(c >= 3 && c < 8);
            if (c == 5) begin
                check("stall_tready", 512'(s_if.tready), 512'(0));
                check("stall_hold", 512'(m_if.tvalid), 512'(4'b0010));
            end
            tick(acc);
            if (acc) begin
                nb++;
                if (nb < 8) drive(8'h00, 1'b0, nb == 7);
                else s_if.tvalid = 1'b0;
            end
        end
        m_if.tready = '1;
        repeat (4) tick(acc);
        check("stall_beats_sent", 512'(nb), 512'(8));
        check("stall_all_delivered", 512'(expq[1].size()), 512'(0));

        send(8'h03, 1'b1, 1'b0);
        out_enable[0] = 1'b0;
        send(8'h00, 1'b0, 1'b0);
        check("en_toggle_b1", 512'(m_if.tvalid), 512'(4'b0001));
        send(8'h00, 1'b0, 1'b1);
        check("en_toggle_b2", 512'(m_if.tvalid), 512'(4'b0001));
        d0 = drop_count;
        send(8'h03, 1'b1, 1'b1);
        check("en_off_tvalid", 512'(m_if.tvalid), 512'(0));
        check("en_off_drops", 512'(drop_count), 512'(d0 + 32'd1));
        out_enable = '1;
        tick(acc);

        for (int k = 0; k < 4; k++) begin
            drive(8'(k * 32), 1'b1, 1'b1);
            wait_acc(cyc);
            check($sformatf("b2b%0d_cycles", k), 512'(cyc), 512'(1));
            check($sformatf("b2b%0d_tvalid", k), 512'(m_if.tvalid), 512'(4'b0001 << k));
        end
        tick(acc);

        send(8'h40, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tvalid", 512'(m_if.tvalid), 512'(0));
        check("midrst_drops", 512'(drop_count), 512'(0));
        check("midrst_tready", 512'(s_if.tready), 512'(0));
        s_if.tvalid = 1'b0;
        for (int i = 0; i < M; i++) expq[i].delete();
        mdl_frame = 1'b0;
        mdl_drops = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(8'h60, 1'b1, 1'b1);
        check("postrst_tvalid", 512'(m_if.tvalid), 512'(4'b1000));
        tick(acc);

        for (int f = 0; f < 300; f++) begin
            rtag = 8'($urandom);
            len  = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                drive(rtag, b == 0, b == len - 1);
                acc = 1'b0;
                for (int c = 0; c < 200 && !acc; c++) begin
                    m_if.tready = M'($urandom | $urandom);
                    enable = ($urandom_range(0, 9) != 0);
                    if ($urandom_range(0, 19) == 0) out_enable = M'($urandom);
                    tick(acc);
                end
                if (!acc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rand_timeout: beat not accepted, required within 200 cycles");
                end
                s_if.tvalid = 1'b0;
                if ($urandom_range(0, 3) == 0) tick(acc);
            end
        end
        m_if.tready = '1;
        enable = 1'b1;
        repeat (6) tick(acc);
        for (int i = 0; i < M; i++)
            check($sformatf("rand_out%0d_drained", i), 512'(expq[i].size()), 512'(0));
        check("rand_drop_count", 512'(drop_count), 512'(mdl_drops));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
